// File: rtl/fluxo_dados_sequencia.sv
// rtl/fluxo_dados_sequencia.sv - parametrised datapath for the sequence-memory game
module fluxo_dados_sequencia #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT   = 5000,
    parameter int TIMEOUT_W = $clog2(TIMEOUT)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] chaves,
    input  logic              zeraE,
    input  logic              contaE,
    input  logic              zeraL,
    input  logic              contaL,
    input  logic              zeraR,
    input  logic              registraR,
    input  logic              zeraT,
    input  logic              contaT,
    output logic              jogada_feita,
    output logic              chavesIgualMemoria,
    output logic              enderecoIgualLimite,
    output logic              fimE,
    output logic              fimL,
    output logic              timeout,
    output logic [ADDR_W-1:0] db_endereco,
    output logic [ADDR_W-1:0] db_limite,
    output logic [DATA_W-1:0] db_jogada,
    output logic [DATA_W-1:0] db_memoria
);

    // Last count value; the counter parks here and timeout stays asserted.
    localparam logic [TIMEOUT_W-1:0] T_MAX = TIMEOUT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0]    endereco_q, endereco_d;
    logic [ADDR_W-1:0]    limite_q, limite_d;
    logic [DATA_W-1:0]    jogada_q, jogada_d;
    logic [DATA_W-1:0]    memoria_q, memoria_d;
    logic                 prev_q, prev_d;
    logic [TIMEOUT_W-1:0] tempo_q, tempo_d;

    // Next-state for counters and key register: zero strobe beats count/load.
    always_comb begin
        endereco_d = endereco_q;
        if (zeraE)
            endereco_d = '0;
        else if (contaE)
            endereco_d = endereco_q + 1'b1;

        limite_d = limite_q;
        if (zeraL)
            limite_d = '0;
        else if (contaL)
            limite_d = limite_q + 1'b1;

        jogada_d = jogada_q;
        if (zeraR)
            jogada_d = '0;
        else if (registraR)
            jogada_d = chaves;

        tempo_d = tempo_q;
        if (zeraT)
            tempo_d = '0;
        else if (contaT && (tempo_q != T_MAX))
            tempo_d = tempo_q + 1'b1;

        prev_d = |chaves;
    end

    // Fixed ROM contents: word a is one-hot with bit (a mod DATA_W) set.
    always_comb begin
        memoria_d = '0;
        for (int i = 0; i < DATA_W; i++)
            memoria_d[i] = ((int'(endereco_q) % DATA_W) == i);
    end

    // State registers; reset overrides every strobe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            endereco_q <= '0;
            limite_q   <= '0;
            jogada_q   <= '0;
            memoria_q  <= '0;
            prev_q     <= 1'b0;
            tempo_q    <= '0;
        end else begin
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            jogada_q   <= jogada_d;
            memoria_q  <= memoria_d;
            prev_q     <= prev_d;
            tempo_q    <= tempo_d;
        end
    end

    // Status decodes are purely combinational over the current register state.
    always_comb begin
        jogada_feita        = (|chaves) & ~prev_q;
        chavesIgualMemoria  = (jogada_q == memoria_q);
        enderecoIgualLimite = (endereco_q == limite_q);
        fimE                = &endereco_q;
        fimL                = &limite_q;
        timeout             = (tempo_q == T_MAX);
        db_endereco         = endereco_q;
        db_limite           = limite_q;
        db_jogada           = jogada_q;
        db_memoria          = memoria_q;
    end

endmodule

// File: doc/fluxo_dados_sequencia.md
# fluxo_dados_sequencia

Parametrised datapath for the sequence-memory game. It is the next generation of the fixed 4-bit/16-entry datapath. Beyond the original address counter, key register, synchronous ROM and equality comparator, it adds a round-limit counter, a play-detect edge detector and a timeout counter. All sequencing decisions stay in the separate control unit, which drives the zero/count/register strobes and reads the status outputs.

## Interface

Parameters:
- `DATA_W`, default 4 — width of switches, key register and ROM word.
- `ADDR_W`, default 4 — address/limit counter width; ROM depth is 2^ADDR_W.
- `TIMEOUT`, default 5000 — cycles of `contaT` before `timeout` asserts; minimum 2.
- `TIMEOUT_W`, default `$clog2(TIMEOUT)` — timeout counter width.

Ports:
- `clock` in 1 — single clock, all state on rising edge.
- `reset_n` in 1 — synchronous, active-low; clears every register listed below.
- `chaves` in `DATA_W` — player switches (one-hot expected, not required).
- `zeraE` / `contaE` in 1 / 1 — address counter clear / increment.
- `zeraL` / `contaL` in 1 / 1 — limit counter clear / increment.
- `zeraR` / `registraR` in 1 / 1 — key register clear / load.
- `zeraT` / `contaT` in 1 / 1 — timeout counter clear / increment.
- `jogada_feita` out 1 — one-cycle pulse on a new play.
- `chavesIgualMemoria` out 1 — key register == ROM output.
- `enderecoIgualLimite` out 1 — address counter == limit counter.
- `fimE` / `fimL` out 1 / 1 — counter at 2^ADDR_W−1.
- `timeout` out 1 — timeout reached.
- `db_endereco` / `db_limite` out `ADDR_W` — counter values.
- `db_jogada` / `db_memoria` out `DATA_W` — key register and ROM output.

## Operation

- Priority in every register: `reset_n` low > zero strobe > count/load strobe > hold.
- Address and limit counters:
  - Increment by 1 and wrap from 2^ADDR_W−1 to 0.
  - `fimE`/`fimL` are combinational decodes of the all-ones value; no enable gating.
- Key register:
  - Loads `chaves` when `registraR`.
  - `zeraR` and `registraR` in the same cycle gives 0.
- ROM:
  - Synchronous read; output register clocked every cycle from the address counter.
  - Fixed contents: `mem[a]` = one-hot with bit (a mod `DATA_W`) set.
  - Reset clears the output register to 0.
- Comparator:
  - `chavesIgualMemoria` = (`db_jogada` == `db_memoria`), combinational over all `DATA_W` bits.
  - `enderecoIgualLimite` is combinational.
- Play detector:
  - Register `prev` = |`chaves`, sampled every cycle.
  - `jogada_feita` = (|`chaves`) & ~`prev`.
  - A held switch yields exactly one pulse; release then press yields a new pulse.
- Timeout counter:
  - Increments while `contaT` and saturates at `TIMEOUT`−1.
  - `timeout` = (count == `TIMEOUT`−1).
  - `timeout` stays high until `zeraT` or reset; further `contaT` is ignored.

## Timing

- Reset values:
  - Both counters 0, key register 0, ROM output 0, `prev` 0, timeout counter 0.
  - Hence `fimE`=`fimL`=0, `timeout`=0, `enderecoIgualLimite`=1, `chavesIgualMemoria`=1.
  - `jogada_feita` = |`chaves`; a switch held through reset release gives one pulse.
- Counter change: visible on `db_*` and the decodes 1 cycle after the strobe edge.
- ROM latency: `db_memoria` reflects the new address 1 cycle after `db_endereco` changes, i.e. 2 edges after `contaE`.
  - The control unit must wait one cycle after incrementing before using `chavesIgualMemoria`.
- Key register load: comparator reflects new data in the cycle after `registraR`.
- `timeout` rises on the edge that makes the count reach `TIMEOUT`−1, i.e. after `TIMEOUT`−1 consecutive `contaT` cycles from 0.
- Reset mid-operation: all state clears on the next edge regardless of strobes; there is no partial state.

## Test plan

- Reset: hold `reset_n`=0 with all strobes high for 3 cycles. Required:
  - Both counters 0, `db_memoria`=0, `timeout`=0.
  - `enderecoIgualLimite`=1, `chavesIgualMemoria`=1.
- ROM/compare sweep (`DATA_W`=4): pulse `contaE` 5 times and wait one cycle. Required:
  - `db_endereco`=5, `db_memoria`=4'b0010.
  - Load `chaves`=4'b0010 → `chavesIgualMemoria`=1; load 4'b0100 → 0.
- Wrap: from address 15, one `contaE` edge. Required:
  - Address becomes 0, `fimE` drops.
  - `fimE` was 1 only while the address was 15.
- Limit match: `contaL` 3 times, `contaE` 3 times. Required:
  - `enderecoIgualLimite` is 1 at 0/0, 0 in between, 1 again at 3/3.
  - `zeraE` and `contaE` together → address 0.
- Play detector: `chaves` 0 → 4'b1000 held 4 cycles → 0 → 4'b0001. Required:
  - Exactly two one-cycle `jogada_feita` pulses, one at each rising press.
- Timeout (`TIMEOUT`=5): `contaT` continuously. Required:
  - `timeout` rises after the 4th edge and stays high through 10 more edges.
  - `zeraT` clears it next edge.
  - `reset_n` low mid-count also clears it.
